uop_cache_port_arbiter: RTL and testbench
=========================================

// Module: uop_cache_port_arbiter
// PURPOSE
// - Shares the single-port uop-cache BRAM (512 x 32b, byte address, 8-byte stride) between two requesters.
// - Requester 1 is the loop-buffer fill path (writes). Requester 2 is the loop replay path (reads).
// - Sits between the loop-buffer FSM and the uop_cache instance.
// - Guarantees at most one BRAM access per cycle, read priority during replay, and bounded write starvation.
// PARAMETERS
// - ADDR_W      9   BRAM address width.
// - DATA_W      32  Instruction width.
// - FIFO_DEPTH  2   Pending-write buffer entries (power of 2, >=2).
// - MAX_STARVE  4   Consecutive read grants allowed while a write is pending.
// PORTS
// - clk         in   1       Single clock, rising edge.
// - reset       in   1       Synchronous, active-high reset.
// - flush       in   1       Mispredict flush; drops pending writes and any in-flight read.
// - fill_valid  in   1       Fill write request.
// - fill_addr   in   ADDR_W  Fill write address.
// - fill_data   in   DATA_W  Fill write data.
// - fill_ready  out  1       Write accepted when fill_valid && fill_ready.
// - rd_req      in   1       Replay read request, level-held until granted.
// - rd_addr     in   ADDR_W  Replay read address.
// - rd_gnt      out  1       Read issued to BRAM this cycle.
// - rd_valid    out  1       rd_data is valid (one cycle after rd_gnt).
// - rd_data     out  DATA_W  Read data.
// - bram_en     out  1       BRAM access enable.
// - bram_we     out  1       BRAM write enable (1 = write, 0 = read).
// - bram_addr   out  ADDR_W  BRAM address.
// - bram_wdata  out  DATA_W  BRAM write data.
// - bram_rdata  in   DATA_W  BRAM read data, 1-cycle latency.
// BEHAVIOUR
// - Reset (sync, high): FIFO empty, starve_cnt=0, rd_valid=0.
//   - While reset is high: rd_gnt=0, bram_en=0, bram_we=0, fill_ready=0.
//   - First cycle after reset: fill_ready=1.
// - Pending-write FIFO:
//   - fill_ready = !full && !reset && !flush.
//   - Push on fill_valid && fill_ready.
//   - Writes always issue from the FIFO head; there is no bypass, so minimum fill-to-BRAM latency is 1 cycle.
//   - Push and pop in the same cycle are legal when not full; count is unchanged.
// - Per-cycle arbitration (combinational from registered state):
//   - RD: rd_req && (fifo_empty || starve_cnt < MAX_STARVE)
//     -> rd_gnt=1, bram_en=1, bram_we=0, bram_addr=rd_addr.
//   - WR: else if !fifo_empty
//     -> pop head, bram_en=1, bram_we=1, bram_addr/bram_wdata = head.
//   - IDLE: else bram_en=0, bram_we=0.
//   - bram_addr and bram_wdata are don't-care when bram_en=0; drive 0.
// - Starvation counter (saturating, width clog2(MAX_STARVE+1)):
//   - RD grant with FIFO non-empty -> increment.
//   - WR -> reset to 0.
//   - FIFO empty -> reset to 0.
//   - Effect: after MAX_STARVE read grants, the next cycle is a forced WR even if rd_req is high.
// - Read return: rd_valid(t+1) = rd_gnt(t) && !flush(t); rd_data = bram_rdata, passed through unregistered.
// - Flush (one-cycle pulse, takes priority over everything except reset):
//   - Same cycle: no grant (bram_en=0, rd_gnt=0), fill_ready=0.
//   - Next edge: FIFO cleared, starve_cnt=0, rd_valid=0.
//   - Next cycle: a read granted in the flush cycle-1 still returns rd_valid=1 (it is not cancelled).
// - Reset asserted mid-operation: same as reset; pending writes are lost.
// - Width: FIFO pointers are clog2(FIFO_DEPTH) bits and wrap naturally; count is clog2(FIFO_DEPTH)+1 bits.
// - Assertions:
//   - never (bram_we && !bram_en);
//   - never (rd_gnt && bram_we);
//   - never push when full;
//   - starve_cnt <= MAX_STARVE.
// STRUCTURE
// - Shared package uop_cache_pkg:
//   - UOP_ADDR_W=9, UOP_DATA_W=32, UOP_STRIDE=8;
//   - typedef fill_entry_t {addr, data}.
//   - Share the same constants with the loop FSM and uop_cache.
// - One sub-module: uop_fill_fifo (sync FIFO of fill_entry_t).
//   - Ports: push, pop, flush, full, empty, head.
// - Arbiter logic, starvation counter and rd_valid pipeline register stay in this module.
// TESTING
// 1. Reset held 3 cycles, then released.
//    -> During reset: bram_en=0, rd_valid=0, fill_ready=0.
//    -> First cycle after release: fill_ready=1.
// 2. Fill writes addr 0x00/0x08/0x10 with data A/B/C, rd_req=0.
//    -> bram writes appear in order, one per cycle, each 1 cycle after push.
//    -> fill_ready drops only if the FIFO fills.
// 3. Write 0x08=0xDEADBEEF, then rd_req at 0x08.
//    -> rd_gnt=1, then rd_valid=1 with rd_data=0xDEADBEEF the next cycle.
// 4. rd_req held high continuously, 2 writes queued, MAX_STARVE=4.
//    -> Grant sequence: 4 reads, 1 write, 4 reads, 1 write.
//    -> rd_gnt=0 exactly on the write cycles.
// 5. FIFO full (2 entries) with fill_valid held.
//    -> fill_ready=0 until a WR pop; no entry is lost or duplicated.
// 6. flush pulse with 2 pending writes and a read granted the cycle before.
//    -> That read returns rd_valid=1.
//    -> No BRAM write occurs for the flushed entries.
//    -> The cycle after flush: FIFO empty, starve_cnt=0.

Source files
------------

// File: rtl/uop_cache_pkg.sv
// Constants and types shared by the loop-buffer FSM, the uop cache and its port arbiter.
package uop_cache_pkg;

  localparam int UOP_ADDR_W = 9;
  localparam int UOP_DATA_W = 32;
  localparam int UOP_STRIDE = 8;

  typedef struct packed {
    logic [UOP_ADDR_W-1:0] addr;
    logic [UOP_DATA_W-1:0] data;
  } fill_entry_t;

  // Which requester owns the BRAM port in the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

endpackage

// File: rtl/uop_cache_port_arbiter_if.sv
// Bundle between the loop-buffer requesters, the port arbiter and the uop-cache BRAM.
interface uop_cache_port_arbiter_if
  import uop_cache_pkg::*;
#(
  parameter int ADDR_W     = UOP_ADDR_W,
  parameter int DATA_W     = UOP_DATA_W,
  parameter int MAX_STARVE = 4
) ();

  localparam int STARVE_W = $clog2(MAX_STARVE + 1);

  // Handshakes: a fill transfers on the cycle fill_valid && fill_ready; rd_req is
  // held until the cycle rd_gnt is high, and its data returns on rd_valid one cycle
  // later; the BRAM port is a plain enable, one access per cycle, read data 1 cycle late.
  logic              flush;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              fill_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata;
  grant_e            dbg_grant;
  logic [STARVE_W-1:0] dbg_starve_cnt;

  modport slave (
    input  flush, fill_valid, fill_addr, fill_data, rd_req, rd_addr, bram_rdata,
    output fill_ready, rd_gnt, rd_valid, rd_data,
    output bram_en, bram_we, bram_addr, bram_wdata,
    output dbg_grant, dbg_starve_cnt
  );

  modport master (
    output flush, fill_valid, fill_addr, fill_data, rd_req, rd_addr, bram_rdata,
    input  fill_ready, rd_gnt, rd_valid, rd_data,
    input  bram_en, bram_we, bram_addr, bram_wdata,
    input  dbg_grant, dbg_starve_cnt
  );

endinterface

// File: rtl/uop_fill_fifo.sv
// Small synchronous FIFO holding fill writes until the arbiter gives them the BRAM port.
module uop_fill_fifo
  import uop_cache_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  fill_entry_t push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output fill_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fill_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage is not reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/uop_cache_port_arbiter.sv
// Shares the single uop-cache BRAM port between fill writes and replay reads:
// reads win, but a pending write is forced through after MAX_STARVE read grants.
module uop_cache_port_arbiter
  import uop_cache_pkg::*;
#(
  parameter int ADDR_W     = UOP_ADDR_W,
  parameter int DATA_W     = UOP_DATA_W,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_STARVE = 4
) (
  input logic                     clk,
  input logic                     reset,
  uop_cache_port_arbiter_if.slave bus
);

  localparam int STARVE_W = $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  logic                fill_ready;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  fill_entry_t         head;
  fill_entry_t         push_data;
  grant_e              grant;
  logic [STARVE_W-1:0] starve_cnt;
  logic                rd_valid_q;
  logic                arb_en;
  logic                arb_we;
  logic [ADDR_W-1:0]   arb_addr;
  logic [DATA_W-1:0]   arb_wdata;

  assign fill_ready = !full && !reset && !bus.flush;
  assign push       = bus.fill_valid && fill_ready;
  assign push_data  = '{addr: bus.fill_addr, data: bus.fill_data};

  uop_fill_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fill_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // Grant decision is purely from registered state plus this cycle's requests.
  always_comb begin
    grant = GNT_IDLE;
    if (!reset && !bus.flush) begin
      if (bus.rd_req && (empty || starve_cnt < STARVE_MAX)) begin
        grant = GNT_RD;
      end else if (!empty) begin
        grant = GNT_WR;
      end
    end
  end

  always_comb begin
    arb_en    = 1'b0;
    arb_we    = 1'b0;
    arb_addr  = '0;
    arb_wdata = '0;
    pop       = 1'b0;
    case (grant)
      GNT_RD: begin
        arb_en   = 1'b1;
        arb_addr = bus.rd_addr;
      end
      GNT_WR: begin
        arb_en    = 1'b1;
        arb_we    = 1'b1;
        arb_addr  = head.addr;
        arb_wdata = head.data;
        pop       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Counts reads that overtook a waiting write; any cycle without that resets it.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      starve_cnt <= '0;
    end else if (grant == GNT_RD && !empty) begin
      starve_cnt <= (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + STARVE_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (grant == GNT_RD) && !bus.flush;
    end
  end

  assign bus.fill_ready     = fill_ready;
  assign bus.rd_gnt         = (grant == GNT_RD);
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_data        = bus.bram_rdata;
  assign bus.bram_en        = arb_en;
  assign bus.bram_we        = arb_we;
  assign bus.bram_addr      = arb_addr;
  assign bus.bram_wdata     = arb_wdata;
  assign bus.dbg_grant      = grant;
  assign bus.dbg_starve_cnt = starve_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(arb_we && !arb_en));
      assert (!((grant == GNT_RD) && arb_we));
      assert (starve_cnt <= STARVE_MAX);
    end
  end

endmodule

// File: tb/tb_uop_cache_port_arbiter.sv
// Randomised bench for the uop-cache port arbiter against a queue-based reference model.
module tb_uop_cache_port_arbiter;
  import uop_cache_pkg::*;

  localparam int DEPTH      = 2;
  localparam int MAX_STARVE = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  uop_cache_port_arbiter_if #(
    .ADDR_W     (UOP_ADDR_W),
    .DATA_W     (UOP_DATA_W),
    .MAX_STARVE (MAX_STARVE)
  ) bus ();

  uop_cache_port_arbiter #(
    .ADDR_W     (UOP_ADDR_W),
    .DATA_W     (UOP_DATA_W),
    .FIFO_DEPTH (DEPTH),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM behavioural model driven by the DUT's port
  logic [31:0] bram_mem [512];
  always @(posedge clk) begin
    if (bus.bram_en === 1'b1) begin
      if (bus.bram_we) bram_mem[bus.bram_addr] <= bus.bram_wdata;
      else             bus.bram_rdata <= bram_mem[bus.bram_addr];
    end
  end

  // reference model state and scoreboard queues
  logic [40:0] pend_q[$];
  logic [31:0] ref_mem [512];
  int          starve;
  logic [57:0] exp_q[$];
  logic [47:0] rd_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s cyc=%0d got=output expected=none", name, cyc);
  endtask

  // One clock: evaluate the reference rules for the inputs already applied.
  task automatic cycle();
    logic        ready;
    grant_e      g;
    logic [40:0] hd;
    #1;
    ready = !reset && !bus.flush && (pend_q.size() < DEPTH);
    g = GNT_IDLE;
    if (!reset && !bus.flush) begin
      if (bus.rd_req && (pend_q.size() == 0 || starve < MAX_STARVE)) g = GNT_RD;
      else if (pend_q.size() > 0) g = GNT_WR;
    end
    check("fill_ready", 64'(bus.fill_ready), 64'(ready));
    check("rd_gnt", 64'(bus.rd_gnt), 64'(g == GNT_RD));
    check("grant", 64'(bus.dbg_grant), 64'(g));
    check("starve_cnt", 64'(bus.dbg_starve_cnt), 64'(starve));
    if (g == GNT_RD) begin
      exp_q.push_back({16'(cyc), 1'b0, bus.rd_addr, 32'h0});
      rd_q.push_back({16'(cyc + 1), ref_mem[bus.rd_addr]});
      starve = (pend_q.size() > 0) ? ((starve < MAX_STARVE) ? starve + 1 : starve) : 0;
    end else if (g == GNT_WR) begin
      hd = pend_q.pop_front();
      exp_q.push_back({16'(cyc), 1'b1, hd});
      ref_mem[hd[40:32]] = hd[31:0];
      starve = 0;
    end else begin
      starve = 0;
    end
    if (bus.fill_valid && ready) pend_q.push_back({bus.fill_addr, bus.fill_data});
    if (reset || bus.flush) begin
      pend_q.delete();
      starve = 0;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic f, input logic fv, input logic [8:0] fa,
                       input logic [31:0] fd, input logic rq, input logic [8:0] ra);
    reset          = r;
    bus.flush      = f;
    bus.fill_valid = fv;
    bus.fill_addr  = fa;
    bus.fill_data  = fd;
    bus.rd_req     = rq;
    bus.rd_addr    = ra;
    cycle();
  endtask

  function automatic logic [8:0] rand_addr();
    return 9'($urandom_range(0, 63) * UOP_STRIDE);
  endfunction

  // monitor: pops expectations whenever the DUT presents an access or read data
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.bram_en === 1'b1) begin
        if (exp_q.size() == 0) unexpected("bram_op");
        else check("bram_op", 64'({16'(cyc), bus.bram_we, bus.bram_addr, bus.bram_wdata}),
                   64'(exp_q.pop_front()));
      end
      if (bus.rd_valid === 1'b1) begin
        if (rd_q.size() == 0) unexpected("rd_valid");
        else check("rd_data", 64'({16'(cyc), bus.rd_data}), 64'(rd_q.pop_front()));
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      bram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    bus.bram_rdata = 32'h0;
    starve         = 0;
    reset          = 1'b1;
    bus.flush      = 1'b0;
    bus.fill_valid = 1'b0;
    bus.fill_addr  = '0;
    bus.fill_data  = '0;
    bus.rd_req     = 1'b0;
    bus.rd_addr    = '0;
    @(negedge clk);

    // reset held 3 cycles, then in-order fills
    repeat (3) drive(1, 0, 0, 9'h000, 32'h0, 0, 9'h000);
    drive(0, 0, 1, 9'h000, 32'hAAAA_0001, 0, 9'h000);
    drive(0, 0, 1, 9'h008, 32'hBBBB_0002, 0, 9'h000);
    drive(0, 0, 1, 9'h010, 32'hCCCC_0003, 0, 9'h000);
    repeat (2) drive(0, 0, 0, 9'h000, 32'h0, 0, 9'h000);

    // write then read back the same address
    drive(0, 0, 1, 9'h008, 32'hDEAD_BEEF, 0, 9'h000);
    drive(0, 0, 0, 9'h000, 32'h0, 0, 9'h000);
    drive(0, 0, 0, 9'h000, 32'h0, 1, 9'h008);
    repeat (2) drive(0, 0, 0, 9'h000, 32'h0, 0, 9'h000);

    // continuous reads against two queued writes: starvation bound
    drive(0, 0, 1, 9'h020, 32'h1111_1111, 1, rand_addr());
    drive(0, 0, 1, 9'h028, 32'h2222_2222, 1, rand_addr());
    repeat (12) drive(0, 0, 0, 9'h000, 32'h0, 1, rand_addr());

    // fill_valid held against a full FIFO
    for (int i = 0; i < 12; i++)
      drive(0, 0, 1, rand_addr(), $urandom, 1'($urandom_range(0, 1)), rand_addr());
    repeat (4) drive(0, 0, 0, 9'h000, 32'h0, 0, 9'h000);

    // flush with two pending writes and a read granted the cycle before
    drive(0, 0, 1, 9'h030, 32'h3333_3333, 1, 9'h008);
    drive(0, 0, 1, 9'h038, 32'h4444_4444, 1, 9'h008);
    drive(0, 0, 0, 9'h000, 32'h0, 1, 9'h008);
    drive(0, 1, 0, 9'h000, 32'h0, 1, 9'h008);
    repeat (3) drive(0, 0, 0, 9'h000, 32'h0, 0, 9'h000);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++)
      drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 2) != 0), rand_addr(), $urandom,
            1'($urandom_range(0, 1)), rand_addr());
    repeat (4) drive(0, 0, 0, 9'h000, 32'h0, 0, 9'h000);

    check("bram_ops_left", 64'(exp_q.size()), 64'(0));
    check("reads_left", 64'(rd_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
